tosc_pattern_gen: RTL and testbench



---
 rtl/tosc_pkg.sv | 14 +
 rtl/tosc_pattern_gen_if.sv | 26 ++
 rtl/tosc_phase_timer.sv | 34 +++
 rtl/tosc_pattern_gen.sv | 119 +++++++++++
 tb/tb_tosc_pattern_gen.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/tosc_pkg.sv
// Shared definitions for the oscillator test-pattern generator: default widths and FSM states.
package tosc_pkg;

  localparam int unsigned DefDivW = 16;
  localparam int unsigned DefCntW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StDone
  } tosc_state_e;

endpackage

// File: rtl/tosc_pattern_gen_if.sv
// Control/status bundle between board-level control (master) and the pattern generator (slave).
interface tosc_pattern_gen_if import tosc_pkg::*; #(
  parameter int unsigned DIV_W = DefDivW,
  parameter int unsigned CNT_W = DefCntW
) ();

  logic             start;
  logic [DIV_W-1:0] half_period;
  logic [CNT_W-1:0] num_periods;
  logic             tout;
  logic             gate;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] period_cnt;

  modport master (
    output start, half_period, num_periods,
    input  tout, gate, busy, done, period_cnt
  );

  modport slave (
    input  start, half_period, num_periods,
    output tout, gate, busy, done, period_cnt
  );

endinterface

// File: rtl/tosc_phase_timer.sv
// Loadable down-counter timing one tout phase; expire_o is high on the last cycle of the phase.
module tosc_phase_timer import tosc_pkg::*; #(
  parameter int unsigned DIV_W = DefDivW
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             reload_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [DIV_W-1:0] count_q, count_d;

  // load_val_i is at least 1, so a phase of length H counts H-1 down to 0.
  always_comb begin
    count_d = count_q;
    if (reload_i) begin
      count_d = load_val_i - DIV_W'(1);
    end else if (count_q != '0) begin
      count_d = count_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == '0);

endmodule

// File: rtl/tosc_pattern_gen.sv
// Burst generator: emits exactly N square-wave periods of half-period H framed by a gate window.
module tosc_pattern_gen import tosc_pkg::*; #(
  parameter int unsigned DIV_W = DefDivW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic                clk,
  input  logic                clr,
  tosc_pattern_gen_if.slave   bus
);

  tosc_state_e      state_q, state_d;
  logic             start_q;
  logic [DIV_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             tout_q, tout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             start_edge;
  logic [DIV_W-1:0] hp_eff;
  logic             timer_reload;
  logic [DIV_W-1:0] timer_load;
  logic             timer_expire;

  assign start_edge = bus.start && !start_q;
  assign hp_eff     = (bus.half_period == '0) ? DIV_W'(1) : bus.half_period;
  // The first HIGH phase is loaded in the launch cycle, before h_q holds the new value.
  assign timer_load = (state_q == StIdle) ? hp_eff : h_q;

  tosc_phase_timer #(
    .DIV_W (DIV_W)
  ) u_phase_timer (
    .clk        (clk),
    .clr        (clr),
    .reload_i   (timer_reload),
    .load_val_i (timer_load),
    .expire_o   (timer_expire)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      h_q          <= DIV_W'(1);
      n_q          <= '0;
      period_cnt_q <= '0;
      tout_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= bus.start;
      h_q          <= h_d;
      n_q          <= n_d;
      period_cnt_q <= period_cnt_d;
      tout_q       <= tout_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    n_d          = n_q;
    period_cnt_d = period_cnt_q;
    timer_reload = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          h_d          = hp_eff;
          n_d          = bus.num_periods;
          period_cnt_d = '0;
          if (bus.num_periods == '0) begin
            state_d = StDone;
          end else begin
            state_d      = StHigh;
            timer_reload = 1'b1;
          end
        end
      end
      StHigh: begin
        if (timer_expire) begin
          state_d      = StLow;
          timer_reload = 1'b1;
        end
      end
      StLow: begin
        if (timer_expire) begin
          period_cnt_d = period_cnt_q + CNT_W'(1);
          if (period_cnt_d == n_q) begin
            state_d = StDone;
          end else begin
            state_d      = StHigh;
            timer_reload = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode the next state so they are registered alongside it.
  always_comb begin
    tout_d = (state_d == StHigh);
    busy_d = (state_d == StHigh) || (state_d == StLow);
    done_d = (state_d == StDone);
  end

  assign bus.tout       = tout_q;
  assign bus.gate       = busy_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.period_cnt = period_cnt_q;

endmodule

// File: tb/tb_tosc_pattern_gen.sv
// Directed bench for tosc_pattern_gen: cycle-by-cycle burst checks plus hand-computed done cycles.
module tb_tosc_pattern_gen;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  tosc_pattern_gen_if #(.DIV_W(16), .CNT_W(16)) bus ();

  tosc_pattern_gen #(
    .DIV_W (16),
    .CNT_W (16)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Expected outputs in cycle c (c >= 1) of a burst launched in cycle 0.
  task automatic check_cycle(input string t, input int c, input int h, input int n);
    int   span;
    logic et, eg, ed;
    int   ec;
    span = 2 * h * n;
    if (c <= span) begin
      et = (((c - 1) / h) % 2) == 0;
      eg = 1'b1;
      ed = 1'b0;
      ec = (c - 1) / (2 * h);
    end else begin
      et = 1'b0;
      eg = 1'b0;
      ed = (c == span + 1);
      ec = n;
    end
    check_eq($sformatf("%s c%0d tout", t, c), 32'(bus.tout), 32'(et));
    check_eq($sformatf("%s c%0d gate", t, c), 32'(bus.gate), 32'(eg));
    check_eq($sformatf("%s c%0d busy", t, c), 32'(bus.busy), 32'(eg));
    check_eq($sformatf("%s c%0d done", t, c), 32'(bus.done), 32'(ed));
    check_eq($sformatf("%s c%0d period_cnt", t, c), 32'(bus.period_cnt), 32'(ec));
  endtask

  task automatic launch(input int hp, input int np);
    @(posedge clk);
    #1;
    bus.start       = 1'b1;
    bus.half_period = 16'(hp);
    bus.num_periods = 16'(np);
  endtask

  task automatic run_burst(input string t, input int h, input int n, input int last,
                           output int done_at);
    done_at = 0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        check_cycle(t, c, h, n);
        if (bus.done && done_at == 0) done_at = c;
      end
    end
  endtask

  task automatic drop_start();
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  int done_at;

  initial begin
    clr             = 1'b0;
    bus.start       = 1'b0;
    bus.half_period = '0;
    bus.num_periods = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst tout", 32'(bus.tout), 32'd0);
    check_eq("rst gate", 32'(bus.gate), 32'd0);
    check_eq("rst busy", 32'(bus.busy), 32'd0);
    check_eq("rst done", 32'(bus.done), 32'd0);
    check_eq("rst period_cnt", 32'(bus.period_cnt), 32'd0);
    clr = 1'b1;

    // H=3, N=2: done at 2*3*2+1 = 13
    launch(3, 2);
    run_burst("t1", 3, 2, 15, done_at);
    check_eq("t1 done cycle", 32'(done_at), 32'd13);
    drop_start();

    // N=0: immediate done, no gate
    launch(5, 0);
    run_burst("t2", 5, 0, 6, done_at);
    check_eq("t2 done cycle", 32'(done_at), 32'd1);
    drop_start();

    // half_period=0 acts as 1: done at 2*1*4+1 = 9
    launch(0, 4);
    run_burst("t3", 1, 4, 11, done_at);
    check_eq("t3 done cycle", 32'(done_at), 32'd9);
    drop_start();

    // start held high for 100 cycles: one burst only
    launch(2, 3);
    run_burst("t4", 2, 3, 100, done_at);
    check_eq("t4 done cycle", 32'(done_at), 32'd13);
    drop_start();
    launch(1, 2);
    run_burst("t4b", 1, 2, 6, done_at);
    check_eq("t4b done cycle", 32'(done_at), 32'd5);
    drop_start();

    // extra edge mid-burst plus num_periods change: both ignored, done at 25
    launch(4, 3);
    done_at = 0;
    for (int c = 0; c <= 28; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        check_cycle("t5", c, 4, 3);
        if (bus.done && done_at == 0) done_at = c;
      end
      if (c == 3) bus.start = 1'b0;
      if (c == 5) begin
        bus.start       = 1'b1;
        bus.num_periods = 16'd1;
      end
    end
    check_eq("t5 done cycle", 32'(done_at), 32'd25);
    drop_start();

    // reset mid-burst at cycle 6 of H=2, N=5
    launch(2, 5);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 1) check_cycle("t6", c, 2, 5);
    end
    clr       = 1'b0;
    bus.start = 1'b0;
    #1;
    check_eq("t6 rst tout", 32'(bus.tout), 32'd0);
    check_eq("t6 rst gate", 32'(bus.gate), 32'd0);
    check_eq("t6 rst busy", 32'(bus.busy), 32'd0);
    check_eq("t6 rst done", 32'(bus.done), 32'd0);
    check_eq("t6 rst period_cnt", 32'(bus.period_cnt), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("t6 hold%0d done", c), 32'(bus.done), 32'd0);
      check_eq($sformatf("t6 hold%0d busy", c), 32'(bus.busy), 32'd0);
    end
    clr = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t6 idle done", 32'(bus.done), 32'd0);
    launch(1, 1);
    run_burst("t6b", 1, 1, 4, done_at);
    check_eq("t6b done cycle", 32'(done_at), 32'd3);
    drop_start();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
